// File: rtl/traffic_phase_seq_if.sv
// Sensor inputs and light-decoder outputs of the traffic phase sequencer.
// The sequencer connects through the slave modport and the sensor/decoder side through master.
interface traffic_phase_seq_if;
  logic        enable;
  logic [31:0] car_num;
  logic        line_sen;
  logic [31:0] counter;
  logic [1:0]  phase;
  logic [7:0]  phase_left;
  logic        phase_start;
  logic [3:0]  ext_used;
  logic [15:0] viol_cnt;

  modport master (
    output enable, car_num, line_sen,
    input  counter, phase, phase_left, phase_start, ext_used, viol_cnt
  );

  modport slave (
    input  enable, car_num, line_sen,
    output counter, phase, phase_left, phase_start, ext_used, viol_cnt
  );
endinterface

// File: rtl/traffic_phase_seq.sv
// Traffic phase sequencer: RED -> YEL1 -> GREEN -> YEL2, tick-timed, with stop-line violation count.
// Define GREEN_EXT_EN to build green extension driven by car_num; otherwise green has a fixed length.
module traffic_phase_seq #(
  parameter int unsigned TICK_DIV      = 1,
  parameter int unsigned RED_TICKS     = 10,
  parameter int unsigned YEL_TICKS     = 2,
  parameter int unsigned GRN_TICKS     = 10,
  parameter int unsigned GRN_EXT_TICKS = 5,
  parameter int unsigned MAX_EXT       = 2,
  parameter int unsigned CAR_THRESH    = 4,
  // Reset values of counter/viol_cnt; non-zero only to preload for test. COUNTER_INIT[1:0] must be 0.
  parameter logic [31:0] COUNTER_INIT  = 32'h0000_0000,
  parameter logic [15:0] VIOL_INIT     = 16'h0000
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_phase_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    RED   = 2'd0,
    YEL1  = 2'd1,
    GREEN = 2'd2,
    YEL2  = 2'd3
  } phase_e;

  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  RED_LEFT = 8'(RED_TICKS - 1);
  localparam logic [7:0]  YEL_LEFT = 8'(YEL_TICKS - 1);
  localparam logic [7:0]  GRN_LEFT = 8'(GRN_TICKS - 1);
  localparam logic [7:0]  EXT_LEFT = 8'(GRN_EXT_TICKS - 1);

  phase_e      state_q, state_d, nxt_c;
  logic [31:0] counter_q, counter_d;
  logic [7:0]  left_q, left_d;
  logic [3:0]  ext_q, ext_d;
  logic        start_q, start_d;
  logic [15:0] viol_q, viol_d;
  logic [15:0] pre_q, pre_d;
  logic        line_q;
  logic        tick_c, edge_c, ext_grant_c;

  function automatic logic [7:0] load_left(input phase_e p);
    case (p)
      RED:     load_left = RED_LEFT;
      GREEN:   load_left = GRN_LEFT;
      default: load_left = YEL_LEFT;
    endcase
  endfunction

  assign tick_c = bus.enable && (pre_q == PRE_LAST);
  assign edge_c = bus.line_sen && !line_q;

`ifdef GREEN_EXT_EN
  localparam logic [31:0] CAR_THRESH_W = 32'(CAR_THRESH);
  localparam logic [3:0]  MAX_EXT_W    = 4'(MAX_EXT);

  // Only consulted on the last green tick, so car_num matters nowhere else.
  assign ext_grant_c = (state_q == GREEN) && (bus.car_num >= CAR_THRESH_W) && (ext_q < MAX_EXT_W);
`else
  logic ext_unused;

  assign ext_grant_c = 1'b0;
  assign ext_unused  = ^{bus.car_num, 32'(CAR_THRESH), 32'(MAX_EXT)};
`endif

  always_comb begin
    nxt_c = RED;
    unique case (state_q)
      RED:     nxt_c = YEL1;
      YEL1:    nxt_c = GREEN;
      GREEN:   nxt_c = YEL2;
      YEL2:    nxt_c = RED;
      default: nxt_c = RED;
    endcase
  end

  // Next-state and output logic; violations are judged against the pre-advance phase.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    left_d    = left_q;
    ext_d     = ext_q;
    start_d   = 1'b0;
    pre_d     = pre_q;
    viol_d    = viol_q;

    if (bus.enable) begin
      pre_d = tick_c ? 16'd0 : 16'(pre_q + 16'd1);
    end

    if (tick_c) begin
      if (left_q != 8'd0) begin
        left_d = 8'(left_q - 8'd1);
      end else if (ext_grant_c) begin
        left_d = EXT_LEFT;
        ext_d  = 4'(ext_q + 4'd1);
      end else begin
        state_d   = nxt_c;
        counter_d = 32'(counter_q + 32'd1);
        left_d    = load_left(nxt_c);
        start_d   = 1'b1;
        if (nxt_c == GREEN) begin
          ext_d = 4'd0;
        end
      end
    end

    if (edge_c && (state_q != GREEN) && (viol_q != 16'hFFFF)) begin
      viol_d = 16'(viol_q + 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RED;
      counter_q <= COUNTER_INIT;
      left_q    <= RED_LEFT;
      ext_q     <= 4'd0;
      start_q   <= 1'b0;
      viol_q    <= VIOL_INIT;
      pre_q     <= 16'd0;
      line_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      left_q    <= left_d;
      ext_q     <= ext_d;
      start_q   <= start_d;
      viol_q    <= viol_d;
      pre_q     <= pre_d;
      line_q    <= bus.line_sen;
    end
  end

  assign bus.counter     = counter_q;
  assign bus.phase       = state_q;
  assign bus.phase_left  = left_q;
  assign bus.phase_start = start_q;
  assign bus.ext_used    = ext_q;
  assign bus.viol_cnt    = viol_q;

endmodule

// File: doc/traffic_phase_seq.md
Name: traffic_phase_seq

Overview:
- Sequencer that drives the traffic-light output decoder.
- Produces the 32-bit phase `counter` (`counter % 4` selects red / yellow / green / yellow) and times each phase in ticks.
- Extends green while the waiting-car count is high, and counts stop-line violations.
- Sits between the intersection sensors (`car_num`, `line_sen`) and the light decoder.

Parameters:
- TICK_DIV, 1, clock cycles per timing tick (1..65535).
- RED_TICKS, 10, red phase length in ticks (1..256).
- YEL_TICKS, 2, each yellow phase length in ticks (1..256).
- GRN_TICKS, 10, base green length in ticks (1..256).
- GRN_EXT_TICKS, 5, ticks added per green extension (1..256).
- MAX_EXT, 2, maximum extensions per green phase (0..15).
- CAR_THRESH, 4, `car_num` value at or above which green is extended.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = sequencer runs; 0 = timing frozen.
- car_num  input  32  number of cars waiting on the controlled approach.
- line_sen  input  1  stop-line sensor, level, synchronous to clk.
- counter  output  32  phase counter to the light decoder; `counter % 4` == phase.
- phase  output  2  0 RED, 1 YEL1, 2 GREEN, 3 YEL2.
- phase_left  output  8  ticks remaining in the current phase, minus 1.
- phase_start  output  1  one-cycle pulse in the first cycle of each new phase.
- ext_used  output  4  extensions granted in the current green phase.
- viol_cnt  output  16  stop-line violation count, saturating.

Behaviour:
- Reset (`rst_n` = 0, asynchronous):
  - `counter` = 0, `phase` = 0, `phase_left` = RED_TICKS-1.
  - `phase_start` = 0, `ext_used` = 0, `viol_cnt` = 0.
  - Prescaler = 0, `line_sen` history register = 0.
  - Reset asserted mid-phase aborts that phase. After release, RED restarts with full length.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1 while `enable` = 1.
  - `tick` = 1 in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - With TICK_DIV = 1, `tick` = `enable` every cycle.
- State machine: RED → YEL1 → GREEN → YEL2 → RED. All transitions happen only on `tick`.
  - On tick with `phase_left` > 0: `phase_left` decrements.
  - On tick with `phase_left` = 0: advance to the next phase and load `phase_left` with (that phase's length)-1.
  - Each phase therefore lasts exactly its length in ticks.
- Counter and phase_start:
  - `counter` increments by 1 on every phase advance and wraps 0xFFFFFFFF → 0. `phase` always equals `counter[1:0]`.
  - `phase_start` = 1 for the single cycle after each advance (registered). It is never asserted after reset.
- Green extension, evaluated on the GREEN tick where `phase_left` = 0:
  - If `car_num` >= CAR_THRESH and `ext_used` < MAX_EXT: stay in GREEN, load `phase_left` = GRN_EXT_TICKS-1, increment `ext_used`. No `counter` change, no `phase_start`.
  - Otherwise advance to YEL2.
  - `ext_used` clears to 0 on entry to GREEN. It holds its value through YEL2 and RED for observation.
  - `car_num` is sampled only at that decision tick; changes at other times have no effect.
- Enable:
  - `enable` = 0 freezes the prescaler, `phase`, `phase_left`, `counter` and `ext_used`. Outputs hold.
  - Re-enabling resumes the same phase with the remaining time. There is no catch-up.
- Violations:
  - Registered `line_sen` history gives a rising edge when `line_sen` = 1 and the history bit = 0.
  - Each rising edge while `phase` != GREEN increments `viol_cnt`. Saturates at 0xFFFF.
  - Counting is independent of `enable`.
  - A rising edge in the same cycle as a phase advance is judged against the pre-advance phase.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: GREEN_EXT_EN.
- Defined: green extension behaves as above.
- Undefined: no extension logic is built. GREEN always lasts GRN_TICKS, `ext_used` is tied to 0, and `car_num` is unused.

Test Plan:
- Reset, then `enable` = 1, `car_num` = 0, defaults → `phase_start` pulses and the `phase` sequence follow 0 (10 cycles), 1 (2), 2 (10), 3 (2), 0. `counter` reads 1, 2, 3, 4 after each advance.
- `car_num` = 7 throughout, GREEN_EXT_EN defined → GREEN lasts 10+5+5 = 20 cycles, `ext_used` = 2, then YEL2. `car_num` = 3 → GREEN lasts 10 cycles.
- TICK_DIV = 3, `enable` low for 5 cycles mid-RED → RED lasts exactly 30+5 clocks; `phase_left` holds its value while low.
- `line_sen` pulsed 3 times in RED, 2 times in GREEN, held high across a RED→YEL1 advance → `viol_cnt` = 3. With `viol_cnt` preloaded via 65537 pulses in RED, it stays at 0xFFFF.
- Force `counter` near wrap (run ≥ 2^32 advances in a shortened sim, or a test-only preload) → 0xFFFFFFFF → 0 while `phase` is YEL2 → RED. `counter[1:0]` always equals `phase`.
- `rst_n` asserted asynchronously mid-GREEN, between clock edges → all outputs reach reset values immediately. After release, RED lasts a full 10 ticks.
